uart_rx_deser: RTL and testbench
================================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, giving clocks per serial bit (12 MHz clk, 115200 baud); legal range 16..65535.
REQ-002 SHALL derive constant HALF = (CLKS_PER_BIT-1)/2, integer division; HALF = 51 at the default.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all flops on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_serial, input, 1 bit: asynchronous UART line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly framed byte; feeds the key decoder/clock-control stage.
REQ-007 SHALL have port rx_data_rdy, output, 1 bit: one-clock pulse, new byte valid on rx_data.
REQ-008 SHALL have port rx_frame_err, output, 1 bit: one-clock pulse, stop bit sampled low.
REQ-009 SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass rx_serial through a 2-flop synchronizer whose flops reset to 1; all FSM decisions use the synchronized value rxs.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP and BREAK, with a bit-period counter cnt and a 3-bit bit index bidx.
REQ-012 IDLE: when rxs==0, SHALL go to START with cnt=0; otherwise SHALL stay in IDLE.
REQ-013 START: at cnt==HALF, if rxs==0 SHALL go to DATA with cnt=0 and bidx=0; if rxs==1 (glitch) SHALL go to IDLE with no output pulse.
REQ-014 DATA: at cnt==CLKS_PER_BIT-1, SHALL shift rxs into shift-register bit bidx (LSB first) and reset cnt to 0; after bidx==7 is sampled, SHALL go to STOP.
REQ-015 STOP: at cnt==CLKS_PER_BIT-1, if rxs==1 SHALL load rx_data from the shift register, pulse rx_data_rdy for the next cycle only, and go to IDLE.
REQ-016 STOP: at cnt==CLKS_PER_BIT-1, if rxs==0 SHALL pulse rx_frame_err for the next cycle only, leave rx_data unchanged, assert no rx_data_rdy, and go to BREAK.
REQ-017 BREAK: SHALL stay in BREAK while rxs==0 and go to IDLE on the first cycle rxs==1, so a held-low line cannot retrigger frames.
REQ-018 Otherwise cnt SHALL increment by 1 per clock; cnt width SHALL be clog2(CLKS_PER_BIT) and cnt SHALL never wrap.
REQ-019 Relative to the first rxs==0 cycle, samples SHALL occur HALF+k*CLKS_PER_BIT(+1) clocks later: k=1..8 for data bits, k=9 for stop.
REQ-020 Returning to IDLE mid-stop-bit SHALL allow a start bit immediately following the stop bit (zero idle gap) to be received.
REQ-021 rx_data_rdy and rx_frame_err SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-022 rx_data SHALL hold its value between rx_data_rdy pulses.
REQ-023 No receive buffering SHALL be provided; the downstream consumer SHALL accept a byte on the rx_data_rdy cycle.

Reset
REQ-024 On rst high, SHALL force: FSM=IDLE, cnt=0, bidx=0, shift register=0, rx_data=8'h00, rx_data_rdy=0, rx_frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-025 Reset SHALL take effect immediately, including mid-frame, and SHALL dominate any simultaneous sample or pulse event.
REQ-026 After rst deasserts, a partially received frame SHALL be discarded and the next full frame SHALL be received normally.

Verification
REQ-027 Send 0x53 ('S') at CLKS_PER_BIT=104 -> rx_data=8'h53; exactly one rx_data_rdy pulse between 988 and 991 clocks after the start edge; rx_frame_err=0.
REQ-028 Send 0x0D then 0x35 back-to-back with no idle gap -> two rx_data_rdy pulses, values 8'h0D then 8'h35, rx_busy returns low only after the second frame.
REQ-029 Drive rx_serial low for 20 clocks, then high -> rx_busy high, then low after about HALF+3 clocks; no rdy pulse and no err pulse.
REQ-030 Send 0x41 with a low stop bit, holding the line low 300 clocks, then send 0x4C -> one rx_frame_err pulse; rx_data keeps its prior value; FSM stays in BREAK until the line goes high; then rx_data=8'h4C with one rdy pulse.
REQ-031 Assert rst during data bit 4 of a frame -> all outputs 0 at once; after release, a following 0x40 ('@') frame is received correctly.
REQ-032 Send 0x5A with bit period 102 and again with bit period 106 -> rx_data=8'h5A in both cases and rx_frame_err=0.

Source files
------------

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// Receives 8N1 UART frames (LSB first) from an asynchronous serial line and
// presents each correctly framed byte with a one-clock valid pulse. Stop bits
// sampled low raise a one-clock frame-error pulse instead, and the receiver
// then waits for the line to go high before it looks for another start bit.
//
// Ports
//   clk          system clock, all flops on the rising edge
//   rst          asynchronous active-high reset
//   rx_serial    asynchronous UART line, idle high
//   rx_data      last correctly framed byte, held between rx_data_rdy pulses
//   rx_data_rdy  one-clock pulse, new byte valid on rx_data
//   rx_frame_err one-clock pulse, stop bit sampled low
//   rx_busy      high whenever a frame (or a line break) is being handled
module uart_rx_deser #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] CntHalf = CntW'(HALF);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntZero = '0;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } stateT;

    // Line synchronizer; both flops reset to the idle (high) level so a reset
    // never looks like a start bit.
    logic rxMeta;
    logic rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rx_serial;
            rxs    <= rxMeta;
        end
    end

    stateT           stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic [2:0]      bidxQ, bidxD;
    logic [7:0]      shiftQ, shiftD;
    logic [7:0]      dataQ, dataD;
    logic            rdyQ, rdyD;
    logic            errQ, errD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            bidxQ  <= '0;
            shiftQ <= '0;
            dataQ  <= '0;
            rdyQ   <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            bidxQ  <= bidxD;
            shiftQ <= shiftD;
            dataQ  <= dataD;
            rdyQ   <= rdyD;
            errQ   <= errD;
        end
    end

    logic halfDone;
    logic bitDone;

    assign halfDone = (cntQ == CntHalf);
    assign bitDone  = (cntQ == CntLast);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        bidxD  = bidxQ;
        shiftD = shiftQ;
        dataD  = dataQ;
        rdyD   = 1'b0;
        errD   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                cntD  = CntZero;
                bidxD = 3'd0;
                if (!rxs) begin
                    stateD = StStart;
                end
            end

            // Re-check the line at mid start bit; a high level here was a
            // glitch and is dropped silently.
            StStart: begin
                if (halfDone) begin
                    cntD   = CntZero;
                    bidxD  = 3'd0;
                    stateD = rxs ? StIdle : StData;
                end else begin
                    cntD = cntQ + CntOne;
                end
            end

            // From here on the counter runs full bit periods, so every sample
            // lands mid-bit, offset by half a period from the start edge.
            StData: begin
                if (bitDone) begin
                    cntD          = CntZero;
                    shiftD[bidxQ] = rxs;
                    bidxD         = bidxQ + 3'd1;
                    if (bidxQ == 3'd7) begin
                        stateD = StStop;
                    end
                end else begin
                    cntD = cntQ + CntOne;
                end
            end

            // Leaving mid stop bit gives half a bit of slack, so a start bit
            // that follows the stop bit with no idle gap is still caught.
            StStop: begin
                if (bitDone) begin
                    cntD = CntZero;
                    if (rxs) begin
                        dataD  = shiftQ;
                        rdyD   = 1'b1;
                        stateD = StIdle;
                    end else begin
                        errD   = 1'b1;
                        stateD = StBreak;
                    end
                end else begin
                    cntD = cntQ + CntOne;
                end
            end

            // A line held low after a bad stop bit must not start new frames.
            StBreak: begin
                cntD = CntZero;
                if (rxs) begin
                    stateD = StIdle;
                end
            end

            default: begin
                stateD = StIdle;
                cntD   = CntZero;
                bidxD  = 3'd0;
            end
        endcase
    end

    assign rx_data      = dataQ;
    assign rx_data_rdy  = rdyQ;
    assign rx_frame_err = errQ;
    assign rx_busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
// Self-checking bench for uart_rx_deser. A bit-level serial driver produces
// frames; a monitor collects every rdy/err pulse. Expected results come from
// a frame-level model: a good frame yields its byte, a low stop bit yields one
// error pulse and leaves the held byte alone.
module tb_uart_rx_deser;

    localparam int CPB  = 104;
    localparam int HALF = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxSerial;
    logic [7:0] rxData;
    logic       rxDataRdy;
    logic       rxFrameErr;
    logic       rxBusy;

    int total = 0;
    int bad   = 0;

    longint     cyc = 0;
    logic [7:0] gotBytes[$];
    longint     gotTimes[$];
    int         errPulses = 0;
    logic       prevPulse = 1'b0;
    logic [7:0] lastGood = 8'h00;

    uart_rx_deser #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rxSerial),
        .rx_data     (rxData),
        .rx_data_rdy (rxDataRdy),
        .rx_frame_err(rxFrameErr),
        .rx_busy     (rxBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records bytes and error pulses, and checks that pulses
    // are single-cycle and never coincide.
    always @(negedge clk) begin
        if (rxDataRdy) begin
            gotBytes.push_back(rxData);
            gotTimes.push_back(cyc);
        end
        if (rxFrameErr) errPulses++;
        if (rxDataRdy || rxFrameErr) begin
            total++;
            if ((rxDataRdy && rxFrameErr) || prevPulse) begin
                bad++;
                $display("FAIL pulse_shape: rdy=%b err=%b prev_pulse=%b, required one isolated pulse",
                         rxDataRdy, rxFrameErr, prevPulse);
            end
        end
        prevPulse = rxDataRdy || rxFrameErr;
    end

    task automatic drive(input logic v, input int n);
        rxSerial = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input int period, input logic stopVal,
                            output logic busyMid);
        busyMid = 1'b0;
        drive(1'b0, period);
        for (int i = 0; i < 8; i++) begin
            drive(b[i], period);
            if (i == 4) busyMid = rxBusy;
        end
        drive(stopVal, period);
    endtask

    task automatic clearMon();
        gotBytes.delete();
        gotTimes.delete();
        errPulses = 0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rxSerial = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (rxData !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", rxData);
        end
        total++;
        if (rxDataRdy !== 1'b0) begin
            bad++; $display("FAIL reset_rdy: got %b want 0", rxDataRdy);
        end
        total++;
        if (rxFrameErr !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b want 0", rxFrameErr);
        end
        total++;
        if (rxBusy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", rxBusy);
        end
        rst = 1'b0;
        lastGood = 8'h00;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        longint t0;
        longint dt;
        logic   bm;
        clearMon();
        t0 = cyc;
        sendByte(8'h53, CPB, 1'b1, bm);
        drive(1'b1, 20);
        total++;
        if (gotBytes.size() != 1) begin
            bad++; $display("FAIL single_count: got %0d pulses want 1", gotBytes.size());
        end
        if (gotBytes.size() >= 1) begin
            total++;
            if (gotBytes[0] !== 8'h53) begin
                bad++; $display("FAIL single_data: got %h want 53", gotBytes[0]);
            end
            dt = gotTimes[0] - t0;
            total++;
            if (dt < 988 || dt > 991) begin
                bad++; $display("FAIL single_latency: got %0d clocks want 988..991", dt);
            end
        end
        total++;
        if (errPulses != 0) begin
            bad++; $display("FAIL single_err: got %0d err pulses want 0", errPulses);
        end
        total++;
        if (bm !== 1'b1) begin
            bad++; $display("FAIL single_busy_mid: got %b want 1", bm);
        end
        total++;
        if (rxBusy !== 1'b0 || rxData !== 8'h53) begin
            bad++; $display("FAIL single_end: busy=%b data=%h want busy=0 data=53", rxBusy, rxData);
        end
        lastGood = 8'h53;
    endtask

    task automatic test_back_to_back();
        logic bm1;
        logic bm2;
        clearMon();
        sendByte(8'h0D, CPB, 1'b1, bm1);
        sendByte(8'h35, CPB, 1'b1, bm2);
        drive(1'b1, 20);
        total++;
        if (gotBytes.size() != 2) begin
            bad++; $display("FAIL b2b_count: got %0d pulses want 2", gotBytes.size());
        end
        if (gotBytes.size() == 2) begin
            total++;
            if (gotBytes[0] !== 8'h0D || gotBytes[1] !== 8'h35) begin
                bad++; $display("FAIL b2b_data: got %h %h want 0d 35", gotBytes[0], gotBytes[1]);
            end
        end
        total++;
        if (bm2 !== 1'b1) begin
            bad++; $display("FAIL b2b_busy_second: got %b want 1", bm2);
        end
        total++;
        if (rxBusy !== 1'b0 || errPulses != 0) begin
            bad++; $display("FAIL b2b_end: busy=%b errs=%0d want busy=0 errs=0", rxBusy, errPulses);
        end
        lastGood = 8'h35;
    endtask

    task automatic test_glitch();
        logic sawHigh;
        int   lowAt;
        clearMon();
        sawHigh = 1'b0;
        lowAt   = -1;
        rxSerial = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 20) rxSerial = 1'b1;
            if (rxBusy) sawHigh = 1'b1;
            if (sawHigh && !rxBusy) begin
                lowAt = n;
                break;
            end
        end
        total++;
        if (!sawHigh || lowAt < HALF + 2 || lowAt > HALF + 6) begin
            bad++; $display("FAIL glitch_busy: high_seen=%b low_after=%0d want low after %0d..%0d",
                            sawHigh, lowAt, HALF + 2, HALF + 6);
        end
        drive(1'b1, 2 * CPB);
        total++;
        if (gotBytes.size() != 0 || errPulses != 0) begin
            bad++; $display("FAIL glitch_pulses: rdy=%0d err=%0d want 0 0", gotBytes.size(), errPulses);
        end
        total++;
        if (rxData !== lastGood) begin
            bad++; $display("FAIL glitch_data: got %h want %h", rxData, lastGood);
        end
    endtask

    task automatic test_frame_error();
        logic bm;
        clearMon();
        sendByte(8'h41, CPB, 1'b0, bm);
        drive(1'b0, 300);
        total++;
        if (errPulses != 1 || gotBytes.size() != 0) begin
            bad++; $display("FAIL ferr_pulses: err=%0d rdy=%0d want 1 0", errPulses, gotBytes.size());
        end
        total++;
        if (rxData !== lastGood) begin
            bad++; $display("FAIL ferr_hold: got %h want %h", rxData, lastGood);
        end
        total++;
        if (rxBusy !== 1'b1) begin
            bad++; $display("FAIL ferr_break_busy: got %b want 1", rxBusy);
        end
        drive(1'b1, 20);
        total++;
        if (rxBusy !== 1'b0) begin
            bad++; $display("FAIL ferr_break_exit: got %b want 0", rxBusy);
        end
        sendByte(8'h4C, CPB, 1'b1, bm);
        drive(1'b1, 20);
        total++;
        if (gotBytes.size() != 1 || errPulses != 1) begin
            bad++; $display("FAIL ferr_recover_count: rdy=%0d err=%0d want 1 1", gotBytes.size(), errPulses);
        end
        total++;
        if (rxData !== 8'h4C) begin
            bad++; $display("FAIL ferr_recover_data: got %h want 4c", rxData);
        end
        lastGood = 8'h4C;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic       bm;
        clearMon();
        b = 8'hA7;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(b[i], CPB);
        rxSerial = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (rxData !== 8'h00 || rxDataRdy !== 1'b0 || rxFrameErr !== 1'b0 || rxBusy !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: data=%h rdy=%b err=%b busy=%b want 00 0 0 0",
                            rxData, rxDataRdy, rxFrameErr, rxBusy);
        end
        lastGood = 8'h00;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2 * CPB);
        sendByte(8'h40, CPB, 1'b1, bm);
        drive(1'b1, 20);
        total++;
        if (gotBytes.size() != 1 || errPulses != 0) begin
            bad++; $display("FAIL midreset_count: rdy=%0d err=%0d want 1 0", gotBytes.size(), errPulses);
        end
        total++;
        if (rxData !== 8'h40) begin
            bad++; $display("FAIL midreset_data: got %h want 40", rxData);
        end
        lastGood = 8'h40;
    endtask

    task automatic test_bit_period();
        int   periods[2];
        logic bm;
        periods[0] = 102;
        periods[1] = 106;
        for (int k = 0; k < 2; k++) begin
            clearMon();
            sendByte(8'h5A, periods[k], 1'b1, bm);
            drive(1'b1, 20);
            total++;
            if (gotBytes.size() != 1 || errPulses != 0 || rxData !== 8'h5A) begin
                bad++; $display("FAIL period_%0d: rdy=%0d err=%0d data=%h want 1 0 5a",
                                periods[k], gotBytes.size(), errPulses, rxData);
            end
        end
        lastGood = 8'h5A;
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        int         expErr;
        logic [7:0] b;
        logic       stopVal;
        logic       bm;
        int         p;
        int         gap;
        clearMon();
        expErr = 0;
        for (int n = 0; n < 10; n++) begin
            b       = 8'($urandom_range(0, 255));
            p       = $urandom_range(100, 108);
            stopVal = ($urandom_range(0, 4) != 0);
            gap     = $urandom_range(0, 40);
            sendByte(b, p, stopVal, bm);
            if (stopVal) begin
                expQ.push_back(b);
                lastGood = b;
            end else begin
                expErr++;
                drive(1'b0, $urandom_range(1, 200));
                gap = gap + CPB;
            end
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, 40);
        total++;
        if (gotBytes.size() != expQ.size() || errPulses != expErr) begin
            bad++; $display("FAIL random_counts: rdy=%0d err=%0d want %0d %0d",
                            gotBytes.size(), errPulses, expQ.size(), expErr);
        end
        for (int i = 0; i < expQ.size() && i < gotBytes.size(); i++) begin
            total++;
            if (gotBytes[i] !== expQ[i]) begin
                bad++; $display("FAIL random_byte_%0d: got %h want %h", i, gotBytes[i], expQ[i]);
            end
        end
        total++;
        if (rxData !== lastGood) begin
            bad++; $display("FAIL random_hold: got %h want %h", rxData, lastGood);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rxSerial = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_bit_period();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
